// File: rtl/output_allocator_rr.sv
// Packet-level round-robin allocator for one output port; optional lock watchdog under `ALLOC_TIMEOUT_EN.
// Latency: grant registered 1 cycle after a head request; out_valid/ack are combinational on the locked input.
// Backpressure: out_stall suppresses ack and holds the lock; the flit waits at its input.
module output_allocator_rr #(
  parameter int N_IN           = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [N_IN-1:0] req,
  input  logic [N_IN-1:0] head,
  input  logic [N_IN-1:0] tail,
  input  logic            out_stall,
  output logic [N_IN-1:0] mux_sel,
  output logic            out_valid,
  output logic [N_IN-1:0] ack,
  output logic            err_timeout
);

  localparam int PW = $clog2(N_IN);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            state_q, state_d;
  logic [N_IN-1:0]   mux_sel_q, mux_sel_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [N_IN-1:0]   cand;
  logic              pick_vld;
  logic [PW-1:0]     pick_idx;
  logic [PW-1:0]     lock_idx;
  logic              lock_req;
  logic              lock_tail;
  logic              transfer;
  logic              wd_fire;
  int                rank;
  int                best;

  assign cand      = req & head;
  assign lock_req  = |(req & mux_sel_q);
  assign lock_tail = |(tail & mux_sel_q);
  assign transfer  = out_valid & ~out_stall;
  assign mux_sel   = mux_sel_q;

  // Rank each candidate by its distance past rr_ptr; the smallest rank wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    rank     = 0;
    best     = N_IN;
    for (int i = 0; i < N_IN; i++) begin
      rank = (i + 2 * N_IN - int'(rr_ptr_q) - 1) % N_IN;
      if (cand[i] && (rank < best)) begin
        best     = rank;
        pick_vld = 1'b1;
        pick_idx = PW'(i);
      end
    end
  end

  always_comb begin
    lock_idx = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (mux_sel_q[i]) lock_idx = PW'(i);
    end
  end

`ifdef ALLOC_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wd_cnt_q;
  logic          err_q;

  // Fires on the TIMEOUT_CYCLES-th consecutive locked cycle without a transfer.
  assign wd_fire     = (state_q == LOCKED) && !transfer && (wd_cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign err_timeout = err_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if ((state_q == IDLE) || transfer || wd_fire) wd_cnt_q <= '0;
      else                                          wd_cnt_q <= wd_cnt_q + 1'b1;
      if (wd_fire) err_q <= 1'b1;
    end
  end
`else
  assign wd_fire     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      mux_sel_q <= '0;
      rr_ptr_q  <= PW'(N_IN - 1);
    end else begin
      state_q   <= state_d;
      mux_sel_q <= mux_sel_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mux_sel_d = mux_sel_q;
    rr_ptr_d  = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d   = LOCKED;
          mux_sel_d = {{(N_IN-1){1'b0}}, 1'b1} << pick_idx;
        end
      end
      LOCKED: begin
        if ((transfer && lock_tail) || wd_fire) begin
          state_d   = IDLE;
          mux_sel_d = '0;
          rr_ptr_d  = lock_idx;
        end
      end
      default: begin
        state_d   = IDLE;
        mux_sel_d = '0;
      end
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    ack       = '0;
    if (state_q == LOCKED) begin
      out_valid = lock_req;
      if (lock_req && !out_stall) ack = mux_sel_q;
    end
  end

endmodule

// File: tb/tb_output_allocator_rr.sv
// Directed bench for output_allocator_rr: per-cycle vector table plus hand sequences for reset/idle/watchdog.
module tb_output_allocator_rr;

  logic       clock;
  logic       reset_n;
  logic [1:0] req;
  logic [1:0] head;
  logic [1:0] tail;
  logic       out_stall;
  logic [1:0] mux_sel;
  logic       out_valid;
  logic [1:0] ack;
  logic       err_timeout;

  int total;
  int bad;

  output_allocator_rr #(
    .N_IN          (2),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req        (req),
    .head       (head),
    .tail       (tail),
    .out_stall  (out_stall),
    .mux_sel    (mux_sel),
    .out_valid  (out_valid),
    .ack        (ack),
    .err_timeout(err_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0] req;
    logic [1:0] head;
    logic [1:0] tail;
    logic       stall;
    logic [1:0] sel;
    logic       valid;
    logic [1:0] ack;
  } vec_t;

  vec_t vecs [31];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] r, input logic [1:0] h, input logic [1:0] t, input logic s);
    req       = r;
    head      = h;
    tail      = t;
    out_stall = s;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  int ack1_cnt;

  initial begin
    total = 0;
    bad   = 0;
    // Each row is one cycle: inputs, then mux_sel/out_valid/ack expected during that cycle.
    // Test 1: both heads, input0 wins, 2-flit pkt, idle cycle, then input1.
    vecs[0]  = '{2'b11, 2'b11, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00};
    vecs[1]  = '{2'b11, 2'b11, 2'b00, 1'b0, 2'b01, 1'b1, 2'b01};
    vecs[2]  = '{2'b11, 2'b10, 2'b01, 1'b0, 2'b01, 1'b1, 2'b01};
    vecs[3]  = '{2'b10, 2'b10, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00};
    vecs[4]  = '{2'b10, 2'b10, 2'b10, 1'b0, 2'b10, 1'b1, 2'b10};
    // Test 2: input1 4-flit pkt, stalls on flits 2 and 3.
    vecs[5]  = '{2'b10, 2'b10, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00};
    vecs[6]  = '{2'b10, 2'b10, 2'b00, 1'b0, 2'b10, 1'b1, 2'b10};
    vecs[7]  = '{2'b10, 2'b00, 2'b00, 1'b1, 2'b10, 1'b1, 2'b00};
    vecs[8]  = '{2'b10, 2'b00, 2'b00, 1'b1, 2'b10, 1'b1, 2'b00};
    vecs[9]  = '{2'b10, 2'b00, 2'b00, 1'b0, 2'b10, 1'b1, 2'b10};
    vecs[10] = '{2'b10, 2'b00, 2'b00, 1'b1, 2'b10, 1'b1, 2'b00};
    vecs[11] = '{2'b10, 2'b00, 2'b00, 1'b0, 2'b10, 1'b1, 2'b10};
    vecs[12] = '{2'b10, 2'b00, 2'b10, 1'b0, 2'b10, 1'b1, 2'b10};
    vecs[13] = '{2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00};
    // Test 3: input0 locked while input1 shows a head; stall, bubble, then single-flit pkts.
    vecs[14] = '{2'b01, 2'b01, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00};
    vecs[15] = '{2'b11, 2'b11, 2'b00, 1'b0, 2'b01, 1'b1, 2'b01};
    vecs[16] = '{2'b11, 2'b11, 2'b00, 1'b1, 2'b01, 1'b1, 2'b00};
    vecs[17] = '{2'b10, 2'b10, 2'b00, 1'b0, 2'b01, 1'b0, 2'b00};
    vecs[18] = '{2'b11, 2'b10, 2'b01, 1'b0, 2'b01, 1'b1, 2'b01};
    vecs[19] = '{2'b10, 2'b10, 2'b10, 1'b0, 2'b00, 1'b0, 2'b00};
    vecs[20] = '{2'b10, 2'b10, 2'b10, 1'b0, 2'b10, 1'b1, 2'b10};
    vecs[21] = '{2'b01, 2'b01, 2'b01, 1'b0, 2'b00, 1'b0, 2'b00};
    vecs[22] = '{2'b01, 2'b01, 2'b01, 1'b0, 2'b01, 1'b1, 2'b01};
    vecs[23] = '{2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00};
    // Fairness: continuous single-flit requests from both inputs alternate.
    vecs[24] = '{2'b11, 2'b11, 2'b11, 1'b0, 2'b00, 1'b0, 2'b00};
    vecs[25] = '{2'b11, 2'b11, 2'b11, 1'b0, 2'b10, 1'b1, 2'b10};
    vecs[26] = '{2'b11, 2'b11, 2'b11, 1'b0, 2'b00, 1'b0, 2'b00};
    vecs[27] = '{2'b11, 2'b11, 2'b11, 1'b0, 2'b01, 1'b1, 2'b01};
    vecs[28] = '{2'b11, 2'b11, 2'b11, 1'b0, 2'b00, 1'b0, 2'b00};
    vecs[29] = '{2'b11, 2'b11, 2'b11, 1'b0, 2'b10, 1'b1, 2'b10};
    vecs[30] = '{2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00};

    reset_n = 1'b0;
    drive(2'b00, 2'b00, 2'b00, 1'b0);
    check("reset_mux_sel", mux_sel, 2'b00);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_ack", ack, 2'b00);
    check("reset_err", err_timeout, 1'b0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    ack1_cnt = 0;
    for (int i = 0; i < 31; i++) begin
      drive(vecs[i].req, vecs[i].head, vecs[i].tail, vecs[i].stall);
      check($sformatf("vec%0d_mux_sel", i), mux_sel, vecs[i].sel);
      check($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].valid);
      check($sformatf("vec%0d_ack", i), ack, vecs[i].ack);
      check($sformatf("vec%0d_err", i), err_timeout, 1'b0);
      if (i >= 5 && i <= 13 && ack[1]) ack1_cnt++;
      tick();
    end
    check("pkt4_ack_pulses", ack1_cnt, 4);

    // Test 5: non-head requests in IDLE are never granted.
    drive(2'b11, 2'b00, 2'b00, 1'b0);
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("nohead_sel_%0d", k), mux_sel, 2'b00);
      check($sformatf("nohead_ack_%0d", k), ack, 2'b00);
    end

    // Test 4: move rr_ptr to 0, lock input0 mid-packet, then async reset.
    drive(2'b01, 2'b01, 2'b01, 1'b0);
    tick();
    check("pre_rst_single_ack", ack, 2'b01);
    tick();
    check("pre_rst_idle", mux_sel, 2'b00);
    drive(2'b01, 2'b01, 2'b00, 1'b0);
    tick();
    check("pre_rst_locked", mux_sel, 2'b01);
    check("pre_rst_ack", ack, 2'b01);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_sel", mux_sel, 2'b00);
    check("async_rst_ack", ack, 2'b00);
    check("async_rst_valid", out_valid, 1'b0);
    #1;
    reset_n = 1'b1;
    drive(2'b11, 2'b11, 2'b00, 1'b0);
    tick();
    check("post_rst_priority", mux_sel, 2'b01);

    // Lock held through bubbles: watchdog drops it after 8 cycles if enabled.
    drive(2'b00, 2'b00, 2'b00, 1'b0);
`ifdef ALLOC_TIMEOUT_EN
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("wd_sel_%0d", k), mux_sel, (k < 8) ? 2'b01 : 2'b00);
      check($sformatf("wd_err_%0d", k), err_timeout, (k < 8) ? 1'b0 : 1'b1);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("wd_sticky_%0d", k), err_timeout, 1'b1);
    end
`else
    for (int k = 0; k < 20; k++) begin
      tick();
      check($sformatf("hold_sel_%0d", k), mux_sel, 2'b01);
      check($sformatf("hold_valid_%0d", k), out_valid, 1'b0);
      check($sformatf("hold_err_%0d", k), err_timeout, 1'b0);
    end
    drive(2'b01, 2'b00, 2'b01, 1'b0);
    check("hold_tail_ack", ack, 2'b01);
    tick();
    check("hold_release", mux_sel, 2'b00);
`endif

    drive(2'b00, 2'b00, 2'b00, 1'b0);
    reset_n = 1'b0;
    #1;
    check("final_rst_err", err_timeout, 1'b0);
    check("final_rst_sel", mux_sel, 2'b00);
    reset_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
